wb_select_stage: RTL and testbench
==================================

Name: wb_select_stage

Overview:
- Parametrised, registered write-back source selector for the multicycle CPU datapath.
- Picks one of N_SRC data sources or a built-in constant, and applies zero or sign extension of half-word or byte data.
- Holds the result in a one-entry output register with valid/ready handshake toward the register file.
- Adds illegal-selector detection, register-0 write suppression, flush, and a retired-write counter.

Parameters:
- N_SRC, 10, number of DATA_W-wide source inputs; legal range 2..15.
- DATA_W, 32, data width; must be ≥ 16.
- SEL_W, 4, selector width; requires 2^SEL_W ≥ N_SRC+1.
- CONST_VAL, 227, value returned when sel == N_SRC.
- REG_ADDR_W, 5, destination register address width.
- COUNT_W, 16, width of the retired-write counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept a request.
- sel  in  SEL_W  source select.
- ext_mode  in  2  extension mode: 00 pass, 01 zero-ext half, 10 sign-ext half, 11 zero-ext byte.
- src_data  in  N_SRC*DATA_W  packed sources; slice i = bits [i*DATA_W +: DATA_W].
- dest_in  in  REG_ADDR_W  destination register.
- flush  in  1  discard held and incoming request.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  consumer accepts the result.
- wb_data  out  DATA_W  selected/extended data.
- wb_dest  out  REG_ADDR_W  registered dest_in.
- wb_we  out  1  register-file write enable.
- sel_err  out  1  sticky illegal-selector flag.
- clr_err  in  1  clears sel_err.
- wb_count  out  COUNT_W  count of completed writes with wb_we=1.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - out_valid=0, wb_data=0, wb_dest=0, wb_we=0, sel_err=0, wb_count=0.
  - Reset mid-transfer drops the held result.
- in_ready = !out_valid || out_ready. Combinational; must not depend on in_valid.
- Accept: in_valid && in_ready && !flush. The result is registered on that edge, so latency is 1 cycle.
- Selection, with v = selected value:
  - sel < N_SRC: v = src slice sel.
  - sel == N_SRC: v = CONST_VAL and ext_mode is ignored.
  - sel > N_SRC: illegal; v = 0.
- Extension, applied to source data only (not the constant):
  - 00: v.
  - 01: zero-extend v[15:0].
  - 10: sign-extend v[15:0] from bit 15.
  - 11: zero-extend v[7:0].
- Registered wb_we = legal sel && (dest_in != 0). Register 0 is never written; wb_data is still latched.
- Illegal accept:
  - Sets sel_err on the accept edge; it stays set until clr_err or reset.
  - The entry still occupies the output with wb_we=0.
- Error set/clear priority: set beats clear in the same cycle.
- Hold: while out_valid && !out_ready, wb_data, wb_dest and wb_we must stay stable.
- Drain + accept in the same cycle: the new result replaces the old and out_valid stays 1 with no bubble.
- Drain without accept: out_valid goes 0 next cycle. wb_data and wb_dest keep their last values; wb_we goes to 0.
- Flush:
  - Next cycle out_valid=0 and wb_we=0.
  - Any incoming request that cycle is dropped.
  - Flush beats accept.
  - sel_err is not changed by a dropped request.
- Counter: wb_count increments on each cycle where out_valid && out_ready && wb_we. It wraps from 2^COUNT_W-1 to 0 and does not change on flush.

Test Plan:
- Reset with reset=0 mid-stream (out_valid=1):
  - Immediately, without a clk edge: all outputs 0, in_ready=1.
  - After release, first accept appears 1 cycle later.
- Sign/zero extension:
  - sel=2, slice2=32'h0000_8001, ext=10, dest=5, out_ready=1 → next cycle wb_data=32'hFFFF_8001, wb_we=1, wb_dest=5.
  - Same with ext=01 → 32'h0000_8001.
  - ext=11 → 32'h0000_0001.
- Constant and illegal selector:
  - sel=10 (N_SRC), ext=10 → wb_data=227.
  - sel=11 → wb_data=0, wb_we=0, sel_err=1, stays 1 until clr_err pulse.
- Back-pressure:
  - out_ready=0 for 3 cycles after accept of 32'hDEAD_BEEF: in_ready=0, output stable.
  - Raise out_ready with a new in_valid → back-to-back with no bubble; wb_count +2.
- Register-0 suppression: dest=0, sel=0, slice0=32'h1234 → wb_we=0, wb_data=32'h1234, wb_count unchanged.
- Flush + wrap:
  - Flush and in_valid together → out_valid=0 next cycle, no counter change.
  - With COUNT_W=2, 5 completed writes → wb_count=1.

Source files
------------

// File: rtl/wb_select_if.sv
// Handshake/data bundle between the write-back selector stage and its neighbours.
// The master side drives requests and out_ready; the slave side is the stage itself.
interface wb_select_if #(
  parameter int N_SRC      = 10,
  parameter int DATA_W     = 32,
  parameter int SEL_W      = 4,
  parameter int REG_ADDR_W = 5,
  parameter int COUNT_W    = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [SEL_W-1:0]          sel;
  logic [1:0]                ext_mode;
  logic [N_SRC*DATA_W-1:0]   src_data;
  logic [REG_ADDR_W-1:0]     dest_in;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         wb_data;
  logic [REG_ADDR_W-1:0]     wb_dest;
  logic                      wb_we;
  logic                      sel_err;
  logic                      clr_err;
  logic [COUNT_W-1:0]        wb_count;

  modport master (
    output in_valid, sel, ext_mode, src_data, dest_in, flush, out_ready, clr_err,
    input  in_ready, out_valid, wb_data, wb_dest, wb_we, sel_err, wb_count
  );

  modport slave (
    input  in_valid, sel, ext_mode, src_data, dest_in, flush, out_ready, clr_err,
    output in_ready, out_valid, wb_data, wb_dest, wb_we, sel_err, wb_count
  );
endinterface

// File: rtl/wb_select_stage.sv
// Registered write-back source selector: picks a source or constant, extends it,
// and holds the result in a one-entry valid/ready output register.
module wb_select_stage #(
  parameter int          N_SRC      = 10,
  parameter int          DATA_W     = 32,
  parameter int          SEL_W      = 4,
  parameter logic [31:0] CONST_VAL  = 32'd227,
  parameter int          REG_ADDR_W = 5,
  parameter int          COUNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  wb_select_if.slave bus
);

  logic [DATA_W-1:0]     src_arr [N_SRC];
  logic [DATA_W-1:0]     src_v;
  logic [DATA_W-1:0]     ext_v;
  logic [DATA_W-1:0]     wb_data_d;
  logic                  wb_we_d;
  logic                  sel_src;
  logic                  sel_const;
  logic                  sel_illegal;
  logic                  accept;
  logic                  drain;

  logic                  out_valid_q;
  logic [DATA_W-1:0]     wb_data_q;
  logic [REG_ADDR_W-1:0] wb_dest_q;
  logic                  wb_we_q;
  logic                  sel_err_q;
  logic [COUNT_W-1:0]    wb_count_q;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign src_arr[gi] = bus.src_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign sel_src     = (bus.sel < SEL_W'(N_SRC));
  assign sel_const   = (bus.sel == SEL_W'(N_SRC));
  assign sel_illegal = !sel_src && !sel_const;

  always_comb begin
    src_v = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (bus.sel == SEL_W'(i)) src_v = src_arr[i];
    end
  end

  always_comb begin
    ext_v = src_v;
    unique case (bus.ext_mode)
      2'b00: ext_v = src_v;
      2'b01: ext_v = {{(DATA_W-16){1'b0}}, src_v[15:0]};
      2'b10: ext_v = {{(DATA_W-16){src_v[15]}}, src_v[15:0]};
      2'b11: ext_v = {{(DATA_W-8){1'b0}}, src_v[7:0]};
      default: ext_v = src_v;
    endcase
  end

  // The constant bypasses extension; an illegal selector yields zero.
  assign wb_data_d = sel_src   ? ext_v :
                     sel_const ? DATA_W'(CONST_VAL) : '0;
  assign wb_we_d   = (sel_src || sel_const) && (bus.dest_in != '0);

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign drain        = out_valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      wb_data_q   <= '0;
      wb_dest_q   <= '0;
      wb_we_q     <= 1'b0;
      sel_err_q   <= 1'b0;
      wb_count_q  <= '0;
    end else begin
      if (bus.flush) begin
        out_valid_q <= 1'b0;
        wb_we_q     <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        wb_data_q   <= wb_data_d;
        wb_dest_q   <= bus.dest_in;
        wb_we_q     <= wb_we_d;
      end else if (drain) begin
        out_valid_q <= 1'b0;
        wb_we_q     <= 1'b0;
      end

      // Setting wins over a simultaneous clear.
      if (accept && sel_illegal) begin
        sel_err_q <= 1'b1;
      end else if (bus.clr_err) begin
        sel_err_q <= 1'b0;
      end

      if (drain && wb_we_q && !bus.flush) begin
        wb_count_q <= wb_count_q + COUNT_W'(1);
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_dest   = wb_dest_q;
  assign bus.wb_we     = wb_we_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.wb_count  = wb_count_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed bench for wb_select_stage: vector table for selection/extension plus
// hand-written sequences for back-pressure, errors, flush, reset and counter wrap.
module tb_wb_select_stage;

  localparam int N_SRC   = 10;
  localparam int DATA_W  = 32;
  localparam int COUNT_W = 2;

  logic clk;
  logic reset;

  wb_select_if #(.N_SRC(N_SRC), .DATA_W(DATA_W), .SEL_W(4), .REG_ADDR_W(5), .COUNT_W(COUNT_W)) bus ();

  wb_select_stage #(
    .N_SRC(N_SRC), .DATA_W(DATA_W), .SEL_W(4), .CONST_VAL(32'd227),
    .REG_ADDR_W(5), .COUNT_W(COUNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model of the output register occupancy and retired-write count.
  logic               m_valid;
  logic               m_we;
  logic [COUNT_W-1:0] exp_cnt;

  typedef struct {
    logic [3:0]  sel;
    logic [1:0]  ext;
    logic [31:0] val;
    logic [4:0]  dest;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] s, input logic [1:0] e, input logic [31:0] v, input logic [4:0] d);
    bus.sel      = s;
    bus.ext_mode = e;
    bus.dest_in  = d;
    bus.src_data = {N_SRC{32'hA5A5_5A5A}};
    if (s < 4'(N_SRC)) bus.src_data[int'(s)*DATA_W +: DATA_W] = v;
  endtask

  function automatic logic req_we(input logic [3:0] s, input logic [4:0] d);
    return (s <= 4'(N_SRC)) && (d != 5'd0);
  endfunction

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic tick();
    logic acc;
    if (m_valid && bus.out_ready && m_we && !bus.flush) exp_cnt = exp_cnt + 1'b1;
    acc = bus.in_valid && (!m_valid || bus.out_ready) && !bus.flush;
    if (bus.flush) begin
      m_valid = 1'b0; m_we = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1; m_we = req_we(bus.sel, bus.dest_in);
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0; m_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_wb_data"},   bus.wb_data,          32'd0);
    chk({tag, "_wb_dest"},   32'(bus.wb_dest),     32'd0);
    chk({tag, "_wb_we"},     32'(bus.wb_we),       32'd0);
    chk({tag, "_sel_err"},   32'(bus.sel_err),     32'd0);
    chk({tag, "_wb_count"},  32'(bus.wb_count),    32'd0);
    chk({tag, "_in_ready"},  32'(bus.in_ready),    32'd1);
  endtask

  initial begin
    vecs[0] = '{sel: 4'd2,  ext: 2'b10, val: 32'h0000_8001, dest: 5'd5,  exp_data: 32'hFFFF_8001, exp_we: 1'b1};
    vecs[1] = '{sel: 4'd2,  ext: 2'b01, val: 32'h0000_8001, dest: 5'd5,  exp_data: 32'h0000_8001, exp_we: 1'b1};
    vecs[2] = '{sel: 4'd2,  ext: 2'b11, val: 32'h0000_8001, dest: 5'd5,  exp_data: 32'h0000_0001, exp_we: 1'b1};
    vecs[3] = '{sel: 4'd3,  ext: 2'b00, val: 32'h1234_5678, dest: 5'd7,  exp_data: 32'h1234_5678, exp_we: 1'b1};
    vecs[4] = '{sel: 4'd10, ext: 2'b10, val: 32'h0000_0000, dest: 5'd4,  exp_data: 32'd227,        exp_we: 1'b1};
    vecs[5] = '{sel: 4'd0,  ext: 2'b00, val: 32'h0000_1234, dest: 5'd0,  exp_data: 32'h0000_1234, exp_we: 1'b0};
    vecs[6] = '{sel: 4'd9,  ext: 2'b10, val: 32'hABCD_7FFF, dest: 5'd31, exp_data: 32'h0000_7FFF, exp_we: 1'b1};

    reset = 1'b0;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1; bus.clr_err = 1'b0;
    set_req(4'd0, 2'b00, 32'd0, 5'd0);
    m_valid = 1'b0; m_we = 1'b0; exp_cnt = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst");
    reset = 1'b1;

    // Selection and extension table, back-to-back with out_ready held high.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_req(vecs[i].sel, vecs[i].ext, vecs[i].val, vecs[i].dest);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i),  bus.wb_data,         vecs[i].exp_data);
      chk($sformatf("vec%0d_we", i),    32'(bus.wb_we),      32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_dest", i),  32'(bus.wb_dest),    32'(vecs[i].dest));
      chk($sformatf("vec%0d_count", i), 32'(bus.wb_count),   32'(exp_cnt));
      $display("vec %0d: sel=%0d ext=%0b data=0x%08h we=%0b count=%0d",
               i, vecs[i].sel, vecs[i].ext, bus.wb_data, bus.wb_we, bus.wb_count);
    end

    // Illegal selector: occupies output with wb_we=0 and sets a sticky flag.
    set_req(4'd11, 2'b00, 32'd0, 5'd3);
    tick();
    chk("illegal_data",  bus.wb_data,         32'd0);
    chk("illegal_we",    32'(bus.wb_we),      32'd0);
    chk("illegal_valid", 32'(bus.out_valid),  32'd1);
    chk("illegal_err",   32'(bus.sel_err),    32'd1);
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("err_sticky",    32'(bus.sel_err),    32'd1);
    chk("drain_valid",   32'(bus.out_valid),  32'd0);
    chk("drain_we",      32'(bus.wb_we),      32'd0);
    chk("drain_data_kept", bus.wb_data,       32'd0);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("err_cleared",   32'(bus.sel_err),    32'd0);
    // Set and clear in the same cycle: set wins.
    bus.clr_err = 1'b1; bus.in_valid = 1'b1;
    set_req(4'd12, 2'b00, 32'd0, 5'd1);
    tick();
    bus.clr_err = 1'b0; bus.in_valid = 1'b0;
    chk("err_set_beats_clr", 32'(bus.sel_err), 32'd1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("err_cleared2",  32'(bus.sel_err),    32'd0);
    $display("seq illegal: sel_err sequence done");

    // Back-pressure: held result stays stable while a different request waits.
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    set_req(4'd1, 2'b00, 32'hDEAD_BEEF, 5'd9);
    tick();
    bus.out_ready = 1'b0;
    set_req(4'd4, 2'b00, 32'h1111_2222, 5'd6);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("bp%0d_in_ready", c), 32'(bus.in_ready),  32'd0);
      chk($sformatf("bp%0d_data", c),     bus.wb_data,         32'hDEAD_BEEF);
      chk($sformatf("bp%0d_dest", c),     32'(bus.wb_dest),    32'd9);
      chk($sformatf("bp%0d_we", c),       32'(bus.wb_we),      32'd1);
    end
    set_req(4'd4, 2'b00, 32'hCAFE_F00D, 5'd10);
    bus.out_ready = 1'b1;
    tick();
    chk("b2b_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_data",  bus.wb_data,        32'hCAFE_F00D);
    chk("b2b_count1", 32'(bus.wb_count), 32'(exp_cnt));
    bus.in_valid = 1'b0;
    tick();
    chk("b2b_count2", 32'(bus.wb_count), 32'(exp_cnt));
    chk("b2b_drained", 32'(bus.out_valid), 32'd0);
    $display("seq backpressure: count=%0d", bus.wb_count);

    // Flush with a held entry and an incoming illegal request.
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    set_req(4'd1, 2'b00, 32'h0000_0055, 5'd2);
    tick();
    chk("pre_flush_valid", 32'(bus.out_valid), 32'd1);
    bus.flush = 1'b1;
    set_req(4'd13, 2'b00, 32'd0, 5'd3);
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_we",    32'(bus.wb_we),     32'd0);
    chk("flush_err",   32'(bus.sel_err),   32'd0);
    chk("flush_count", 32'(bus.wb_count),  32'(exp_cnt));
    $display("seq flush: out_valid=%0b count=%0d", bus.out_valid, bus.wb_count);

    // Asynchronous reset mid-stream, then one-cycle latency after release.
    bus.in_valid = 1'b1;
    set_req(4'd5, 2'b00, 32'h0BAD_F00D, 5'd8);
    tick();
    bus.in_valid = 1'b0;
    chk("prereset_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    m_valid = 1'b0; m_we = 1'b0; exp_cnt = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    set_req(4'd6, 2'b00, 32'h0000_00AB, 5'd1);
    tick();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_data",  bus.wb_data,        32'h0000_00AB);
    $display("seq reset: first result 0x%08h", bus.wb_data);

    // Counter wrap: five retired writes on a 2-bit counter leave it at 1.
    for (int k = 1; k < 5; k++) begin
      set_req(4'd6, 2'b00, 32'(k), 5'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("wrap_model", 32'(bus.wb_count), 32'(exp_cnt));
    chk("wrap_count", 32'(bus.wb_count), 32'd1);
    $display("seq wrap: count=%0d", bus.wb_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
